fpu_req_responder: RTL and testbench

Sequential request/response front end for the combinational `fpu_top` core: it accepts one operation per valid/ready handshake, registers operands, holds them stable for a fixed settle window, captures the result and flags, and returns them over a backpressure-capable response channel. It sits between a stimulus or command source, such as a bus bridge or random test driver, and the FPU. It also keeps per-operation and per-flag statistics counters for on-chip verification.

---
 rtl/fpu_req_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fpu_req_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : fpu_req_responder (with its combinational core fpu_top)
// Purpose  : valid/ready request/response wrapper around a single-precision
//            add/sub/mul/div core, plus saturating per-op/per-flag counters.
//            Counters are built only when FPU_RESP_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module fpu_top (
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_error,
  output logic        o_underflow,
  output logic        o_overflow
);
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_DIV = 2'b11;

  // Denormals are flushed to zero; truncation rounding; NaN/Inf inputs and x/0 flag an error.
  logic        w_sa, w_sb, w_sb_eff, w_za, w_zb, w_swap, w_sbig, w_ssml, w_err;
  logic [7:0]  w_ea, w_eb, w_ebig, w_dexp;
  logic [23:0] w_ma, w_mb, w_mbig, w_msml, w_msml_sh, w_div;
  logic [24:0] w_sum;
  logic        w_s, w_zero, w_found, w_unused;
  logic [9:0]  w_e;
  logic [23:0] w_m;
  logic [4:0]  w_lz;
  logic [47:0] w_prod, w_quot;

  assign w_sa      = i_a[31];
  assign w_sb      = i_b[31];
  assign w_ea      = i_a[30:23];
  assign w_eb      = i_b[30:23];
  assign w_za      = (w_ea == 8'd0);
  assign w_zb      = (w_eb == 8'd0);
  assign w_ma      = w_za ? 24'd0 : {1'b1, i_a[22:0]};
  assign w_mb      = w_zb ? 24'd0 : {1'b1, i_b[22:0]};
  assign w_sb_eff  = w_sb ^ (i_op == c_OP_SUB);
  assign w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
  assign w_ebig    = w_swap ? w_eb : w_ea;
  assign w_dexp    = w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
  assign w_mbig    = w_swap ? w_mb : w_ma;
  assign w_msml    = w_swap ? w_ma : w_mb;
  assign w_sbig    = w_swap ? w_sb_eff : w_sa;
  assign w_ssml    = w_swap ? w_sa : w_sb_eff;
  assign w_msml_sh = (w_dexp > 8'd23) ? 24'd0 : (w_msml >> w_dexp);
  assign w_sum     = (w_sbig == w_ssml) ? ({1'b0, w_mbig} + {1'b0, w_msml_sh})
                                        : ({1'b0, w_mbig} - {1'b0, w_msml_sh});
  assign w_div     = w_zb ? 24'd1 : w_mb;
  assign w_err     = (w_ea == 8'hFF) | (w_eb == 8'hFF) | ((i_op == c_OP_DIV) & w_zb);

  always_comb begin
    w_s     = 1'b0;
    w_e     = '0;
    w_m     = '0;
    w_zero  = 1'b0;
    w_lz    = '0;
    w_found = 1'b0;
    w_prod  = '0;
    w_quot  = '0;
    case (i_op)
      c_OP_MUL: begin
        w_s    = w_sa ^ w_sb;
        w_zero = w_za | w_zb;
        w_prod = {24'd0, w_ma} * {24'd0, w_mb};
        w_e    = 10'(w_ea) + 10'(w_eb) - 10'd127;
        if (w_prod[47]) begin
          w_m = w_prod[47:24];
          w_e = w_e + 10'd1;
        end else begin
          w_m = w_prod[46:23];
        end
      end
      c_OP_DIV: begin
        w_s    = w_sa ^ w_sb;
        w_zero = w_za;
        w_quot = {w_ma, 24'd0} / {24'd0, w_div};
        w_e    = 10'(w_ea) - 10'(w_eb) + 10'd127;
        if (w_quot[24]) begin
          w_m = w_quot[24:1];
        end else begin
          w_m = w_quot[23:0];
          w_e = w_e - 10'd1;
        end
      end
      default: begin
        w_s = w_sbig;
        w_e = 10'(w_ebig);
        if (w_sum == 25'd0) begin
          w_zero = 1'b1;
          w_s    = 1'b0;
        end else if (w_sum[24]) begin
          w_m = w_sum[24:1];
          w_e = w_e + 10'd1;
        end else begin
          for (int i = 23; i >= 0; i--) begin
            if (!w_found) begin
              if (w_sum[i]) w_found = 1'b1;
              else          w_lz    = w_lz + 5'd1;
            end
          end
          w_m = w_sum[23:0] << w_lz;
          w_e = w_e - 10'(w_lz);
        end
      end
    endcase
  end

  always_comb begin
    o_result    = {w_s, w_e[7:0], w_m[22:0]};
    o_error     = 1'b0;
    o_underflow = 1'b0;
    o_overflow  = 1'b0;
    if (w_err) begin
      o_error  = 1'b1;
      o_result = 32'h7FC0_0000;
    end else if (w_zero) begin
      o_result = {w_s, 31'd0};
    end else if ($signed(w_e) >= 10'sd255) begin
      o_overflow = 1'b1;
      o_result   = {w_s, 8'hFF, 23'd0};
    end else if ($signed(w_e) <= 10'sd0) begin
      o_underflow = 1'b1;
      o_result    = {w_s, 31'd0};
    end
  end

  assign w_unused = ^{w_prod[22:0], w_quot[47:25], w_m[23]};
endmodule

module fpu_req_responder #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [31:0]      rsp_result,
  output logic             rsp_error,
  output logic             rsp_underflow,
  output logic             rsp_overflow,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [CNT_W-1:0] cnt_mul,
  output logic [CNT_W-1:0] cnt_div,
  output logic [CNT_W-1:0] cnt_err,
  output logic [CNT_W-1:0] cnt_uf,
  output logic [CNT_W-1:0] cnt_of
);
  localparam logic [3:0] c_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_lat;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, w_res;
  logic        w_err, w_uf, w_of;
  logic        w_accept, w_capture, w_hs;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign w_accept  = (r_state == S_IDLE) & req_valid;
  assign w_capture = (r_state == S_EXEC) & (r_lat == 4'd0);
  assign w_hs      = (r_state == S_RESP) & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)      w_next = S_EXEC;
      S_EXEC:  if (r_lat == 4'd0)  w_next = S_RESP;
      S_RESP:  if (rsp_ready)      w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat         <= '0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      rsp_op        <= '0;
      rsp_result    <= '0;
      rsp_error     <= 1'b0;
      rsp_underflow <= 1'b0;
      rsp_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_a   <= req_a;
        r_b   <= req_b;
        r_lat <= c_LOAD;
      end else if ((r_state == S_EXEC) && (r_lat != 4'd0)) begin
        r_lat <= r_lat - 4'd1;
      end
      if (w_capture) begin
        rsp_op        <= r_op;
        rsp_result    <= w_res;
        rsp_error     <= w_err;
        rsp_underflow <= w_uf;
        rsp_overflow  <= w_of;
      end
    end
  end

  fpu_top u_fpu (
    .i_op        (r_op),
    .i_a         (r_a),
    .i_b         (r_b),
    .o_result    (w_res),
    .o_error     (w_err),
    .o_underflow (w_uf),
    .o_overflow  (w_of)
  );

`ifdef FPU_RESP_STATS_EN
  logic [CNT_W-1:0] r_cnt [7];
  logic [6:0]       w_inc;

  // Index order: add, sub, mul, div, err, uf, of.
  assign w_inc = {rsp_overflow, rsp_underflow, rsp_error,
                  rsp_op == 2'b11, rsp_op == 2'b10, rsp_op == 2'b01, rsp_op == 2'b00};

  for (genvar g = 0; g < 7; g++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
        r_cnt[g] <= '0;
      end else if (w_hs && w_inc[g] && (r_cnt[g] != {CNT_W{1'b1}})) begin
        r_cnt[g] <= r_cnt[g] + CNT_W'(1);
      end
    end
  end

  assign cnt_add = r_cnt[0];
  assign cnt_sub = r_cnt[1];
  assign cnt_mul = r_cnt[2];
  assign cnt_div = r_cnt[3];
  assign cnt_err = r_cnt[4];
  assign cnt_uf  = r_cnt[5];
  assign cnt_of  = r_cnt[6];
`else
  logic w_unused_stats;
  assign w_unused_stats = stat_clr ^ w_hs;
  assign cnt_add = '0;
  assign cnt_sub = '0;
  assign cnt_mul = '0;
  assign cnt_div = '0;
  assign cnt_err = '0;
  assign cnt_uf  = '0;
  assign cnt_of  = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_fpu_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_req_responder
// Purpose  : directed plus randomized checks of fpu_req_responder against an
//            integer-arithmetic reference and a saturating counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_req_responder;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 2;
`ifdef FPU_RESP_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b0, stat_clr = 1'b0;
  logic [1:0] req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_error, rsp_underflow, rsp_overflow;
  logic [1:0] rsp_op;
  logic [31:0] rsp_result;
  logic [CNT_W-1:0] cnt_add, cnt_sub, cnt_mul, cnt_div, cnt_err, cnt_uf, cnt_of;

  int n_cmp = 0, n_err = 0;
  int m_cnt [7];

  fpu_req_responder #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_underflow(rsp_underflow), .rsp_overflow(rsp_overflow),
    .stat_clr(stat_clr), .cnt_add(cnt_add), .cnt_sub(cnt_sub), .cnt_mul(cnt_mul),
    .cnt_div(cnt_div), .cnt_err(cnt_err), .cnt_uf(cnt_uf), .cnt_of(cnt_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int i);
    return STATS_EN ? 32'(m_cnt[i]) : 32'd0;
  endfunction

  task automatic chk_cnts(input string tag);
    chk({tag, " cnt_add"}, 32'(cnt_add), exp_cnt(0));
    chk({tag, " cnt_sub"}, 32'(cnt_sub), exp_cnt(1));
    chk({tag, " cnt_mul"}, 32'(cnt_mul), exp_cnt(2));
    chk({tag, " cnt_div"}, 32'(cnt_div), exp_cnt(3));
    chk({tag, " cnt_err"}, 32'(cnt_err), exp_cnt(4));
    chk({tag, " cnt_uf"},  32'(cnt_uf),  exp_cnt(5));
    chk({tag, " cnt_of"},  32'(cnt_of),  exp_cnt(6));
  endtask

  // Exact integer to single-precision encoding (magnitudes here stay far below 2^24).
  function automatic logic [31:0] i2f(input int v);
    int mag, p;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    return {v < 0, 8'(127 + p), 23'((mag << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  function automatic int rnd_nz();
    int v;
    v = int'($urandom_range(1, 255));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  // One full transaction: issue, latency check, optional backpressure, handshake, counters.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic [2:0] exp_flags,
                      input int hold, input bit clr, input string tag);
    int n;
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LATENCY));
    chk({tag, " result"}, rsp_result, exp_res);
    chk({tag, " op"}, 32'(rsp_op), 32'(op));
    chk({tag, " flags"}, {29'd0, rsp_error, rsp_underflow, rsp_overflow}, {29'd0, exp_flags});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'b01; req_a = 32'h4120_0000;
      @(posedge clk); #1;
      chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " hold result"}, rsp_result, exp_res);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1; stat_clr = clr;
    @(posedge clk); #1;
    rsp_ready = 1'b0; stat_clr = 1'b0;
    if (clr) begin
      for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    end else begin
      m_cnt[op] = (m_cnt[op] < SAT) ? m_cnt[op] + 1 : SAT;
      for (int i = 0; i < 3; i++)
        if (exp_flags[2 - i]) m_cnt[4 + i] = (m_cnt[4 + i] < SAT) ? m_cnt[4 + i] + 1 : SAT;
    end
    chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " post req_ready"}, 32'(req_ready), 32'd1);
    chk_cnts(tag);
  endtask

  initial begin
    int a, b, q, r, op, hold;
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_op", 32'(rsp_op), 32'd0);
    chk("reset rsp_result", rsp_result, 32'd0);
    chk("reset flags", {29'd0, rsp_error, rsp_underflow, rsp_overflow}, 32'd0);
    chk_cnts("reset");

    send(2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 0, 1'b0, "add");
    send(2'b10, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000, 5, 1'b0, "mul_bp");
    send(2'b11, 32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 0, 1'b0, "div0");
    send(2'b10, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b001, 1, 1'b0, "ovf");
    send(2'b10, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010, 0, 1'b0, "unf");

    // Reset while in EXEC: in-flight op vanishes, counters return to zero.
    req_op = 2'b01; req_a = 32'h4040_0000; req_b = 32'h3F80_0000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    chk("rstexec req_ready", 32'(req_ready), 32'd1);
    chk_cnts("rstexec");
    for (int i = 0; i < LATENCY + 2; i++) begin
      @(posedge clk); #1;
      chk("rstexec no rsp", 32'(rsp_valid), 32'd0);
    end

    for (int i = 0; i < 5; i++)
      send(2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 0, 1'b0, "sat");
    chk("sat cnt_add", 32'(cnt_add), STATS_EN ? 32'(SAT) : 32'd0);
    send(2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 0, 1'b1, "clr");

    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      a = rnd_nz(); b = rnd_nz();
      case (op)
        0: r = a + b;
        1: r = a - b;
        2: r = a * b;
        default: begin q = rnd_nz(); a = b * q; r = q; end
      endcase
      send(2'(op), i2f(a), i2f(b), i2f(r), 3'b000, hold, 1'b0, "rand");
    end

    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    chk_cnts("final clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
